// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter in front of a single-port, fixed-latency memory.
// Each access is serialised as IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  // state  | meaning
  // IDLE   | no access; arbitrate among pending requests
  // ACCESS | mem_en strobe with the granted port's request
  // WAIT   | MEM_LAT cycles for read data; capture on the last one
  // DONE   | ack pulse to the granted port
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] win_q;
  logic [1:0] pick;
  logic [3:0] cnt;

  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lg);
    logic [1:0] p0, p1, p2;
    p0 = (lg == 2'd0) ? 2'd1 : (lg == 2'd1) ? 2'd2 : 2'd0;
    p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    if (r[p0])      return p0;
    else if (r[p1]) return p1;
    else            return p2;
  endfunction

  always_comb pick = rr_pick(req, last_grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      win_q      <= 2'd0;
      cnt        <= 4'd0;
      gnt        <= 3'b000;
      ack        <= 3'b000;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            // The mem_* registers double as the latched request for the access.
            win_q     <= pick;
            mem_we    <= we[pick];
            mem_addr  <= addr[pick*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[pick*DATA_W +: DATA_W];
            mem_en    <= 1'b1;
            gnt       <= 3'b001 << pick;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
          cnt        <= 4'(MEM_LAT - 1);
          last_grant <= win_q;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rdata <= mem_rdata;
            ack   <= 3'b001 << win_q;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ack   <= 3'b000;
          gnt   <= 3'b000;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-stage behavioural memory (MEM_LAT=2).
module tb_mem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      req = 3'b000;
  logic [2:0]      we = 3'b000;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt, ack;
  logic [DW-1:0]   rdata;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: read data appears LAT cycles after the mem_en cycle.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe0 = '0, pipe1 = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_en)       mem[pl_a] <= pl_d;
    pipe0 <= mem[mem_addr];
    pipe1 <= pipe0;
  end
  assign mem_rdata = pipe1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  // Hold r for four back-to-back accesses; expected grant order is o0..o3.
  task automatic run_pattern(input string tag, input logic [2:0] r,
                             input logic [1:0] o0, input logic [1:0] o1,
                             input logic [1:0] o2, input logic [1:0] o3);
    logic [1:0] ord [4];
    logic [2:0] g;
    int ph, k;
    ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
    req = r;
    for (int c = 1; c <= 20; c++) begin
      tick();
      ph = c % 5;
      k  = (c / 5 > 3) ? 3 : c / 5;
      g  = 3'b001 << ord[k];
      chk({tag, " gnt"},    32'(gnt),    (ph != 0) ? 32'(g) : 32'd0);
      chk({tag, " mem_en"}, 32'(mem_en), (ph == 1) ? 32'd1 : 32'd0);
      chk({tag, " ack"},    32'(ack),    (ph == 4) ? 32'(g) : 32'd0);
    end
    req = 3'b000;
  endtask

  initial begin
    tick();
    tick();
    chk_zero("reset outputs");
    preload(8'h15, 4'hA);
    preload(8'h10, 4'h5);
    preload(8'h20, 4'hC);
    reset = 1'b1;
    tick();

    // Single read on port 2
    addr[2*AW +: AW] = 8'h15;
    req = 3'b100;
    chk("rd t busy", 32'(busy), 32'd0);
    tick();
    chk("rd t1 mem_en", 32'(mem_en), 32'd1);
    chk("rd t1 mem_we", 32'(mem_we), 32'd0);
    chk("rd t1 mem_addr", 32'(mem_addr), 32'h15);
    chk("rd t1 gnt", 32'(gnt), 32'b100);
    chk("rd t1 busy", 32'(busy), 32'd1);
    req = 3'b000;
    tick();
    chk("rd t2 mem_en", 32'(mem_en), 32'd0);
    chk("rd t2 mem_addr", 32'(mem_addr), 32'd0);
    chk("rd t2 busy", 32'(busy), 32'd1);
    chk("rd t2 ack", 32'(ack), 32'd0);
    tick();
    chk("rd t3 ack", 32'(ack), 32'd0);
    chk("rd t3 busy", 32'(busy), 32'd1);
    tick();
    chk("rd t4 ack", 32'(ack), 32'b100);
    chk("rd t4 rdata", 32'(rdata), 32'hA);
    chk("rd t4 busy", 32'(busy), 32'd1);
    tick();
    chk("rd t5 ack", 32'(ack), 32'd0);
    chk("rd t5 busy", 32'(busy), 32'd0);
    chk("rd t5 gnt", 32'(gnt), 32'd0);

    // Single write on port 1
    we = 3'b010;
    addr[AW +: AW] = 8'h03;
    wdata[DW +: DW] = 4'h7;
    req = 3'b010;
    tick();
    chk("wr t1 mem_en", 32'(mem_en), 32'd1);
    chk("wr t1 mem_we", 32'(mem_we), 32'd1);
    chk("wr t1 mem_addr", 32'(mem_addr), 32'h03);
    chk("wr t1 mem_wdata", 32'(mem_wdata), 32'h7);
    chk("wr t1 gnt", 32'(gnt), 32'b010);
    req = 3'b000;
    we = 3'b000;
    tick();
    chk("wr t2 mem_we", 32'(mem_we), 32'd0);
    chk("wr t2 mem_wdata", 32'(mem_wdata), 32'd0);
    tick();
    chk("wr t3 ack", 32'(ack), 32'd0);
    tick();
    chk("wr t4 ack", 32'(ack), 32'b010);
    tick();
    chk("wr t5 ack", 32'(ack), 32'd0);

    // Read-back of 0x03 on port 0
    addr[0 +: AW] = 8'h03;
    req = 3'b001;
    tick();
    chk("rb t1 gnt", 32'(gnt), 32'b001);
    chk("rb t1 mem_addr", 32'(mem_addr), 32'h03);
    req = 3'b000;
    tick();
    tick();
    tick();
    chk("rb t4 ack", 32'(ack), 32'b001);
    chk("rb t4 rdata", 32'(rdata), 32'h7);
    tick();

    // Fresh reset, then all three ports and then ports 1/2 continuously
    reset = 1'b0;
    addr = '0;
    tick();
    reset = 1'b1;
    run_pattern("all3", 3'b111, 2'd0, 2'd1, 2'd2, 2'd0);
    run_pattern("p12", 3'b110, 2'd1, 2'd2, 2'd1, 2'd2);

    // Port 0 changes addr after grant
    addr[0 +: AW] = 8'h10;
    req = 3'b001;
    tick();
    chk("chg t1 mem_addr", 32'(mem_addr), 32'h10);
    req = 3'b000;
    tick();
    addr[0 +: AW] = 8'h20;
    chk("chg t2 mem_addr", 32'(mem_addr), 32'd0);
    tick();
    chk("chg t3 mem_addr", 32'(mem_addr), 32'd0);
    chk("chg t3 mem_en", 32'(mem_en), 32'd0);
    tick();
    chk("chg t4 ack", 32'(ack), 32'b001);
    chk("chg t4 rdata", 32'(rdata), 32'h5);
    tick();

    // Reset in the middle of a port-1 access, port 0 pending
    addr[0 +: AW] = 8'h10;
    addr[AW +: AW] = 8'h20;
    req = 3'b010;
    tick();
    chk("mr t1 gnt", 32'(gnt), 32'b010);
    req = 3'b011;
    tick();
    reset = 1'b0;
    #1;
    chk_zero("mr async zero");
    tick();
    chk_zero("mr held zero");
    reset = 1'b1;
    tick();
    chk("mr gnt p0 first", 32'(gnt), 32'b001);
    chk("mr mem_addr", 32'(mem_addr), 32'h10);
    tick();
    chk("mr t2 ack", 32'(ack), 32'd0);
    tick();
    chk("mr t3 ack", 32'(ack), 32'd0);
    tick();
    chk("mr t4 ack", 32'(ack), 32'b001);
    chk("mr t4 rdata", 32'(rdata), 32'h5);
    req = 3'b000;
    tick();
    chk("mr t5 ack", 32'(ack), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
